spwm_channel: RTL

- One half-cycle PWM channel of the SPWM generator. Two instances exist: positive half and negative half.
- Each instance sits downstream of the sequencing FSM and the sample-index up/down counter.
- On each count pulse it fetches the sine duty for the current quarter-wave index and runs one carrier period.
- It drives the gate output and returns a single-cycle ready pulse. That pulse is the FSM's rdyP or rdyN.

---
 rtl/spwm_pkg.sv | 17 +
 rtl/spwm_channel_if.sv | 27 ++
 rtl/spwm_sine_rom.sv | 31 +++
 rtl/spwm_channel.sv | 134 +++++++++++++
 4 files changed

// File: rtl/spwm_pkg.sv
// Shared definitions for the SPWM generator channels.
// Contents: channel FSM state enum and default width/dead-time constants.
package spwm_pkg;

  // Channel sequencing: wait for start, address ROM, latch duty, run one carrier period.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StFetch = 2'd2,
    StRun   = 2'd3
  } spwm_state_e;

  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned IDX_W_DEF    = 6;
  localparam int unsigned DEAD_CYC_DEF = 4;

endpackage

// File: rtl/spwm_channel_if.sv
// Control/status bundle between the SPWM sequencing FSM (master) and one
// half-cycle PWM channel (slave).
//   en, rst_syn, start, sample_idx : FSM -> channel
//   pwm, pwm_n, rdy, duty          : channel -> FSM / gate driver
interface spwm_channel_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = 6
);
  logic             en;
  logic             rst_syn;
  logic             start;
  logic [IDX_W-1:0] sample_idx;
  logic             pwm;
  logic             pwm_n;
  logic             rdy;
  logic [CNT_W-1:0] duty;

  modport master (
    output en, rst_syn, start, sample_idx,
    input  pwm, pwm_n, rdy, duty
  );

  modport slave (
    input  en, rst_syn, start, sample_idx,
    output pwm, pwm_n, rdy, duty
  );
endinterface

// File: rtl/spwm_sine_rom.sv
// Registered quarter-wave sine ROM, one clock of read latency.
// Entry i = round((2^CNT_W-1) * sin(pi*(i+1) / (2*2^IDX_W))); last entry is full scale.
//   clk    : clock
//   addr_i : quarter-wave sample index
//   data_o : duty value, valid the cycle after addr_i
module spwm_sine_rom #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr_i,
  output logic [CNT_W-1:0] data_o
);

  localparam int unsigned Depth     = 2 ** IDX_W;
  localparam real         Pi        = 3.14159265358979323846;
  localparam real         FullScale = $itor((2 ** CNT_W) - 1);

  logic [CNT_W-1:0] rom_tbl [Depth];

  // Table is folded to constants at elaboration; values are non-negative so +0.5 rounds.
  for (genvar i = 0; i < Depth; i++) begin : g_rom
    localparam real Amp = FullScale * $sin(Pi * $itor(i + 1) / $itor(2 * Depth));
    assign rom_tbl[i] = CNT_W'($rtoi(Amp + 0.5));
  end

  always_ff @(posedge clk) begin
    data_o <= rom_tbl[addr_i];
  end

endmodule

// File: rtl/spwm_channel.sv
// One half-cycle SPWM channel. Each accepted start fetches the sine duty for
// sample_idx and runs one 2^CNT_W-clock carrier period, pulsing rdy in its last clock.
//   clk, rst : clock, asynchronous active-high reset
//   ch_io    : slave side of spwm_channel_if (en, rst_syn, start, sample_idx in;
//              pwm, pwm_n, rdy, duty out)
// Optional: define SPWM_DEADTIME_EN to delay rising edges of pwm and the
// complementary pwm_n by DEAD_CYC clocks; otherwise pwm_n is tied 0.
module spwm_channel
  import spwm_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned DEAD_CYC = DEAD_CYC_DEF
) (
  input logic          clk,
  input logic          rst,
  spwm_channel_if.slave ch_io
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  spwm_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] rom_q;
  logic             pwm_q, pwm_d;
  logic             rdy_q, rdy_d;
  logic             run_d, cmp_d;

  // ROM is read every clock; the value captured at the ARM->FETCH edge is the one used.
  spwm_sine_rom #(
    .CNT_W(CNT_W),
    .IDX_W(IDX_W)
  ) u_rom (
    .clk   (clk),
    .addr_i(ch_io.sample_idx),
    .data_o(rom_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    if (ch_io.rst_syn || !ch_io.en) begin
      state_d = StIdle;
      cnt_d   = '0;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        StIdle:  if (ch_io.start) state_d = StArm;
        StArm:   state_d = StFetch;
        StFetch: begin
          duty_d  = rom_q;
          cnt_d   = '0;
          state_d = StRun;
        end
        StRun: begin
          if (cnt_q == CntMax) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from next-state values and registered, so they line up
  // with state/cnt in the same cycle and cannot glitch.
  assign run_d = (state_d == StRun);
  assign cmp_d = run_d && (cnt_d < duty_d);
  assign rdy_d = run_d && (cnt_d == CntMax);

`ifdef SPWM_DEADTIME_EN
  localparam logic [CNT_W-1:0] DeadCyc = CNT_W'(DEAD_CYC);

  logic [CNT_W-1:0] hi_run_q, hi_run_d;
  logic [CNT_W-1:0] lo_run_q, lo_run_d;
  logic             pwm_n_q, pwm_n_d;
  logic             nraw_d;

  // Run-length counters saturate at DeadCyc+1; an output goes high only once its raw
  // level has held for more than DEAD_CYC clocks, so short pulses vanish entirely.
  always_comb begin
    nraw_d   = run_d && !cmp_d;
    hi_run_d = '0;
    lo_run_d = '0;
    if (cmp_d)  hi_run_d = (hi_run_q > DeadCyc) ? hi_run_q : hi_run_q + CNT_W'(1);
    if (nraw_d) lo_run_d = (lo_run_q > DeadCyc) ? lo_run_q : lo_run_q + CNT_W'(1);
    pwm_d   = cmp_d && (hi_run_d > DeadCyc);
    pwm_n_d = nraw_d && (lo_run_d > DeadCyc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_run_q <= '0;
      lo_run_q <= '0;
      pwm_n_q  <= 1'b0;
    end else begin
      hi_run_q <= hi_run_d;
      lo_run_q <= lo_run_d;
      pwm_n_q  <= pwm_n_d;
    end
  end

  assign ch_io.pwm_n = pwm_n_q;
`else
  assign pwm_d       = cmp_d;
  assign ch_io.pwm_n = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      rdy_q   <= rdy_d;
    end
  end

  assign ch_io.pwm  = pwm_q;
  assign ch_io.rdy  = rdy_q;
  assign ch_io.duty = duty_q;

endmodule
